// File: rtl/vga_frame_scanner.sv
// ---------------------------------------------------------------------------
// vga_frame_scanner
//
// Raster scanner for a 640x480@60 VGA output. It reads a 320x320 8-bit image
// from a pixel memory with a combinational read port and centres the image on
// the screen. Pixels outside the image window are shown as BG_COLOR.
//
// Pipeline, where each stage advances only on a pix_en tick:
//   position (h_cnt, v_cnt)
//     -> stage 1: registers the decode and presents mem_addr
//     -> stage 2: registers pix_out and the delayed sync/valid signals
// A position therefore appears on the display outputs exactly two ticks after
// the counters reach it. Its memory address is presented one tick after.
//
// Optional feature (compile-time macro SCANNER_PATTERN_EN):
//   This macro adds an input port named pattern_sel. When pattern_sel is 1,
//   in-window pixels show the test pattern (img_x ^ img_y) instead of
//   mem_data. Address sequencing is the same in both modes.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous, active-high reset (overrides pix_en)
//   pix_en       in   pixel-rate enable; all state holds while low
//   pattern_sel  in   (SCANNER_PATTERN_EN only) select the test pattern
//   mem_addr     out  linear read address, y*IMG_W + x
//   mem_data     in   pixel for mem_addr, same cycle
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   pix_valid    out  displayed pixel lies in the visible area
//   pix_out      out  displayed pixel value
//   frame_start  out  one-clk pulse on the tick where the counters wrap to (0,0)
//
// pix_en acts as a qualifier, not a handshake. The memory has no valid/ready
// signals: the scanner assumes mem_data is valid in the same cycle as mem_addr.
// ---------------------------------------------------------------------------
module vga_frame_scanner #(
    parameter int         H_ACTIVE = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_ACTIVE = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         IMG_W    = 320,
    parameter int         IMG_H    = 320,
    parameter int         X_OFF    = 160,
    parameter int         Y_OFF    = 80,
    parameter int         ADDR_W   = 18,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
`ifdef SCANNER_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              hsync,
    output logic              vsync,
    output logic              pix_valid,
    output logic [7:0]        pix_out,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    // Counter-width constants, so the comparisons have matching widths.
    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_LO  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_HI  = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [H_W-1:0] X_LO   = H_W'(X_OFF);
    localparam logic [H_W-1:0] X_HI   = H_W'(X_OFF + IMG_W);

    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_LO  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_HI  = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [V_W-1:0] Y_LO   = V_W'(Y_OFF);
    localparam logic [V_W-1:0] Y_HI   = V_W'(Y_OFF + IMG_H);

    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [ADDR_W-1:0] lin_addr;

    // Decode of the current counter position
    logic h_last, v_last, wrap;
    logic vis, win, hs, vs;

    // Stage 1 registers
    logic vis_d1, win_d1, hs_d1, vs_d1;
    logic [7:0] pix_sel;

    always_comb begin
        h_last = (h_cnt == H_LAST);
        v_last = (v_cnt == V_LAST);
        wrap   = h_last && v_last;
        vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        win    = (h_cnt >= X_LO) && (h_cnt < X_HI) &&
                 (v_cnt >= Y_LO) && (v_cnt < Y_HI);
        hs     = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
        vs     = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));
    end

    // Position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
            end else begin
                h_cnt <= h_cnt + H_W'(1);
            end
        end
    end

    // Stage 1: address generation and decode delay. The window is scanned in
    // raster order, so the linear address is a running count of the window
    // pixels in this frame. No multiplier is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lin_addr <= '0;
            mem_addr <= '0;
            vis_d1   <= 1'b0;
            win_d1   <= 1'b0;
            hs_d1    <= 1'b1;
            vs_d1    <= 1'b1;
        end else if (pix_en) begin
            vis_d1 <= vis;
            win_d1 <= win;
            hs_d1  <= hs;
            vs_d1  <= vs;
            if (win) begin
                mem_addr <= lin_addr;
            end
            if (wrap) begin
                lin_addr <= '0;
            end else if (win) begin
                lin_addr <= lin_addr + ADDR_W'(1);
            end
        end
    end

`ifdef SCANNER_PATTERN_EN
    logic [7:0] pat_d1;

    // Pattern value for the position that is in stage 1. Only the low 8 bits
    // of the image coordinates are used.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_d1 <= 8'h00;
        end else if (pix_en) begin
            pat_d1 <= 8'(h_cnt - X_LO) ^ 8'(v_cnt - Y_LO);
        end
    end
`endif

    // Pixel select for the stage-1 position. The window lies inside the
    // visible area, so outside the window (including blanking) the pixel
    // is BG_COLOR.
    always_comb begin
        pix_sel = BG_COLOR;
        if (win_d1) begin
            pix_sel = mem_data;
`ifdef SCANNER_PATTERN_EN
            if (pattern_sel) begin
                pix_sel = pat_d1;
            end
`endif
        end
    end

    // Stage 2: display outputs. frame_start is cleared on every clock where
    // pix_en is low, so it is high for exactly one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_out     <= 8'h00;
            pix_valid   <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            pix_out     <= pix_sel;
            pix_valid   <= vis_d1;
            hsync       <= hs_d1;
            vsync       <= vs_d1;
            frame_start <= wrap;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule
